datapath_arbiter: RTL and testbench
===================================

DATAPATH_ARBITER -- requirements
Module: datapath_arbiter

Interface
REQ-001 Parameter: CNT_W, default 8, width of completed-job counter.
REQ-002 Port: clk  in  1  single clock; all state updates on rising edge.
REQ-003 Port: reset  in  1  asynchronous, active-high reset.
REQ-004 Port: req  in  2  per-requester job request, level; bit i = requester i.
REQ-005 Port: gnt  out  2  one-hot grant, held high for the whole job.
REQ-006 Port: done  out  2  one-cycle completion pulse to the granted requester.
REQ-007 Port: busy  out  1  high while any job is active (states RUN or DONE).
REQ-008 Port: step  out  3  current job step 0..5; 0 when not in RUN.
REQ-009 Port: load  out  5  datapath register load enables.
REQ-010 Port: oe  out  12  datapath tri-state output enables.
REQ-011 Port: c1  out  2  ALU1 op: 00 abs, 01 min, 10 max, 11 none-op (high-Z).
REQ-012 Port: c2  out  2  ALU2 op: 00 add, 01 sub, 10 max, 11 none-op (high-Z).
REQ-013 Port: jobs  out  CNT_W  count of completed jobs.

Function
REQ-014 FSM states SHALL be IDLE, RUN, DONE; all outputs SHALL be registered or decoded from registered state only (no combinational req->output path).
REQ-015 In IDLE with req != 00, next edge SHALL enter RUN with step=0 and gnt set to the winner.
REQ-016 Arbitration SHALL be round-robin: req=01 -> requester 0; req=10 -> requester 1; req=11 -> requester other than last-served pointer.
REQ-017 Last-served pointer SHALL update to the winner on the grant edge.
REQ-018 In RUN, step SHALL increment by 1 per cycle 0..5; at step 5 next edge SHALL enter DONE.
REQ-019 In DONE, done SHALL equal gnt for exactly one cycle, gnt stays asserted, jobs SHALL increment by 1 (wrap 2^CNT_W-1 -> 0); next edge SHALL enter IDLE with gnt=00.
REQ-020 Job latency: req sampled at edge k -> gnt high cycles k+1..k+7, step 0 at k+1, step 5 at k+6, done at k+7, IDLE at k+8; minimum one IDLE cycle between jobs.
REQ-021 Deasserting req during RUN/DONE SHALL NOT abort or alter the job; req changes are ignored outside IDLE.
REQ-022 Step controls (load, c1, c2, oe) SHALL be:
  step0: 00011, 11, 11, 000000100100
  step1: 00001, 00, 11, 000000001001
  step2: 00010, 00, 11, 000000010010
  step3: 10000, 01, 11, 000000000010
  step4: 01100, 10, 11, 000001000010
  step5: 00000, 11, (00 if gnt=01, 01 if gnt=10), 101000000000
REQ-023 In IDLE and DONE: load=00000, c1=11, c2=11, oe=000000000000, step=0.
REQ-024 At most one bit of gnt and of done SHALL ever be high; oe SHALL never enable ALU1 and ALU2 outputs while the corresponding c1/c2 is 11.

Reset
REQ-025 reset high SHALL immediately (no clock) force IDLE, gnt=00, done=00, busy=0, step=0, load=00000, c1=11, c2=11, oe=0, jobs=0, last-served pointer=1 (requester 0 wins first tie).
REQ-026 Reset asserted mid-job SHALL abandon the job with no done pulse and no jobs increment; after release, arbitration restarts from IDLE on the first edge.

Verification
REQ-027 Single request: req=01 one cycle at edge k -> gnt=01 k+1..k+7, step 0..5 at k+1..k+6 with REQ-022 controls, c2=00 at step5, done=01 at k+7, jobs=1.
REQ-028 Tie after reset: req=11 held -> jobs granted 01,10,01,10; step5 c2 alternates 00,01; each done matches its gnt; one IDLE cycle between jobs.
REQ-029 Request drop: req=10 granted then req=00 at step 2 -> job runs to step 5, done=10 at k+7.
REQ-030 Reset mid-job: assert reset during step 3 -> all outputs at reset values without clock edge, jobs unchanged at 0, no done pulse.
REQ-031 Counter wrap: CNT_W=2, run 5 jobs -> jobs sequence 1,2,3,0,1.
REQ-032 Idle check: req=00 for 20 cycles -> busy=0, gnt=00, c1=c2=11, oe=0 throughout.

Source files
------------

// File: rtl/datapath_arbiter.sv
// Two-requester round-robin arbiter that sequences a fixed six-step datapath job
// per grant and counts completed jobs.
module datapath_arbiter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       req,
  output logic [1:0]       gnt,
  output logic [1:0]       done,
  output logic             busy,
  output logic [2:0]       step,
  output logic [4:0]       load,
  output logic [11:0]      oe,
  output logic [1:0]       c1,
  output logic [1:0]       c2,
  output logic [CNT_W-1:0] jobs
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e           state_q, state_d;
  logic [2:0]       step_q, step_d;
  logic [1:0]       gnt_q, gnt_d;
  logic             last_q, last_d;
  logic [CNT_W-1:0] jobs_q, jobs_d;
  logic             win;

  // last_q resets to 1 so requester 0 wins the first tie
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      step_q  <= 3'd0;
      gnt_q   <= 2'b00;
      last_q  <= 1'b1;
      jobs_q  <= '0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
      jobs_q  <= jobs_d;
    end
  end

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    gnt_d   = gnt_q;
    last_d  = last_q;
    jobs_d  = jobs_q;
    win     = 1'b0;
    case (state_q)
      IDLE: begin
        if (req != 2'b00) begin
          if (req == 2'b01)      win = 1'b0;
          else if (req == 2'b10) win = 1'b1;
          else                   win = ~last_q;
          state_d = RUN;
          step_d  = 3'd0;
          gnt_d   = win ? 2'b10 : 2'b01;
          last_d  = win;
        end
      end
      RUN: begin
        if (step_q == 3'd5) begin
          state_d = DONE;
          step_d  = 3'd0;
        end else begin
          step_d = step_q + 3'd1;
        end
      end
      DONE: begin
        state_d = IDLE;
        gnt_d   = 2'b00;
        jobs_d  = jobs_q + CNT_W'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  // Every output is decoded from registered state; req never reaches an output
  always_comb begin
    gnt  = gnt_q;
    jobs = jobs_q;
    busy = (state_q != IDLE);
    done = (state_q == DONE) ? gnt_q : 2'b00;
    step = 3'd0;
    load = 5'b00000;
    c1   = 2'b11;
    c2   = 2'b11;
    oe   = 12'b000000000000;
    if (state_q == RUN) begin
      step = step_q;
      case (step_q)
        3'd0: begin load = 5'b00011; oe = 12'b000000100100; end
        3'd1: begin load = 5'b00001; c1 = 2'b00; oe = 12'b000000001001; end
        3'd2: begin load = 5'b00010; c1 = 2'b00; oe = 12'b000000010010; end
        3'd3: begin load = 5'b10000; c1 = 2'b01; oe = 12'b000000000010; end
        3'd4: begin load = 5'b01100; c1 = 2'b10; oe = 12'b000001000010; end
        3'd5: begin
          c2 = gnt_q[1] ? 2'b01 : 2'b00;
          oe = 12'b101000000000;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_datapath_arbiter.sv
// Directed bench for datapath_arbiter (CNT_W=2 so the job counter wraps quickly).
module tb_datapath_arbiter;

  logic        clk;
  logic        reset;
  logic [1:0]  req;
  logic [1:0]  gnt;
  logic [1:0]  done;
  logic        busy;
  logic [2:0]  step;
  logic [4:0]  load;
  logic [11:0] oe;
  logic [1:0]  c1;
  logic [1:0]  c2;
  logic [1:0]  jobs;

  int testCount = 0;
  int failCount = 0;
  int expJobs   = 0;

  logic [4:0]  tLoad [0:5] = '{5'b00011, 5'b00001, 5'b00010, 5'b10000, 5'b01100, 5'b00000};
  logic [1:0]  tC1   [0:5] = '{2'b11, 2'b00, 2'b00, 2'b01, 2'b10, 2'b11};
  logic [11:0] tOe   [0:5] = '{12'b000000100100, 12'b000000001001, 12'b000000010010,
                               12'b000000000010, 12'b000001000010, 12'b101000000000};

  datapath_arbiter #(.CNT_W(2)) dut (
    .clk   (clk),
    .reset (reset),
    .req   (req),
    .gnt   (gnt),
    .done  (done),
    .busy  (busy),
    .step  (step),
    .load  (load),
    .oe    (oe),
    .c1    (c1),
    .c2    (c2),
    .jobs  (jobs)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    testCount++;
    assert (obs === exp) else begin
      failCount++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic checkIdle(input string tag);
    checkOutput({tag, " gnt"},  32'(gnt),  32'(2'b00));
    checkOutput({tag, " done"}, 32'(done), 32'(2'b00));
    checkOutput({tag, " busy"}, 32'(busy), 32'(1'b0));
    checkOutput({tag, " step"}, 32'(step), 32'(3'd0));
    checkOutput({tag, " load"}, 32'(load), 32'(5'b00000));
    checkOutput({tag, " c1"},   32'(c1),   32'(2'b11));
    checkOutput({tag, " c2"},   32'(c2),   32'(2'b11));
    checkOutput({tag, " oe"},   32'(oe),   32'(12'b0));
  endtask

  task automatic checkReset(input string tag);
    checkIdle(tag);
    checkOutput({tag, " jobs"}, 32'(jobs), 32'(2'd0));
  endtask

  // Runs one job from the edge that samples req; dropAt picks the step where req is cleared (6 = never)
  task automatic applyStimulus(input logic [1:0] expGnt, input int dropAt);
    string t;
    tick();
    for (int s = 0; s < 6; s++) begin
      t = $sformatf("job g%0b s%0d", expGnt, s);
      checkOutput({t, " gnt"},  32'(gnt),  32'(expGnt));
      checkOutput({t, " busy"}, 32'(busy), 32'(1'b1));
      checkOutput({t, " done"}, 32'(done), 32'(2'b00));
      checkOutput({t, " step"}, 32'(step), 32'(s));
      checkOutput({t, " load"}, 32'(load), 32'(tLoad[s]));
      checkOutput({t, " c1"},   32'(c1),   32'(tC1[s]));
      checkOutput({t, " c2"},   32'(c2),
                  (s == 5) ? ((expGnt == 2'b01) ? 32'(2'b00) : 32'(2'b01)) : 32'(2'b11));
      checkOutput({t, " oe"},   32'(oe),   32'(tOe[s]));
      if (s == dropAt) req = 2'b00;
      tick();
    end
    t = $sformatf("done g%0b", expGnt);
    checkOutput({t, " done"}, 32'(done), 32'(expGnt));
    checkOutput({t, " gnt"},  32'(gnt),  32'(expGnt));
    checkOutput({t, " busy"}, 32'(busy), 32'(1'b1));
    checkOutput({t, " step"}, 32'(step), 32'(3'd0));
    checkOutput({t, " load"}, 32'(load), 32'(5'b00000));
    checkOutput({t, " c1"},   32'(c1),   32'(2'b11));
    checkOutput({t, " c2"},   32'(c2),   32'(2'b11));
    checkOutput({t, " oe"},   32'(oe),   32'(12'b0));
    expJobs = (expJobs + 1) % 4;
    tick();
    checkIdle($sformatf("after g%0b", expGnt));
    checkOutput($sformatf("after g%0b jobs", expGnt), 32'(jobs), 32'(expJobs));
  endtask

  initial begin
    reset = 1'b1;
    req   = 2'b00;
    #2;
    checkReset("por");
    tick();
    reset = 1'b0;
    tick();
    checkReset("post_release");

    // Tie straight after reset: requester 0 first, then alternation
    req = 2'b11;
    applyStimulus(2'b01, 6);
    applyStimulus(2'b10, 6);
    applyStimulus(2'b01, 6);
    applyStimulus(2'b10, 6);

    // Single one-cycle request
    req = 2'b01;
    applyStimulus(2'b01, 0);

    // Request dropped at step 2 must not disturb the job
    req = 2'b10;
    applyStimulus(2'b10, 2);

    for (int i = 0; i < 20; i++) begin
      tick();
      checkIdle($sformatf("idle c%0d", i));
    end

    // Reset asserted mid-job, between edges
    req = 2'b01;
    tick();
    req = 2'b00;
    tick();
    tick();
    tick();
    checkOutput("pre_rst step", 32'(step), 32'(3'd3));
    #3;
    reset = 1'b1;
    #1;
    checkReset("rst_mid");
    expJobs = 0;
    tick();
    checkReset("rst_held");
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      checkReset($sformatf("rst_after c%0d", i));
    end

    // Pointer restored by reset, then counter wraps 1,2,3,0,1
    req = 2'b11;
    applyStimulus(2'b01, 0);
    for (int i = 0; i < 4; i++) begin
      req = 2'b01;
      applyStimulus(2'b01, 0);
    end

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
